// File: rtl/fp_normalize.sv
// Normalizes a raw add/sub magnitude into an IEEE-754 single; done pulses 1 cycle after capture plus one cycle per left shift (max 23).
// Backpressure: in_ready is high only while idle, so one operation is in flight at a time.
module fp_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic [31:0] result,
  output logic        done,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [24:0] mant_q;

  logic [8:0]  exp_inc;
  logic        fin;
  logic [31:0] res_nxt;
  logic        ov_nxt;
  logic        un_nxt;

  assign exp_inc = {1'b0, exp_q} + 9'd1;

  // Outcome of the current NORM cycle; fin=0 means another left shift is needed.
  always_comb begin
    fin     = 1'b1;
    res_nxt = 32'h0000_0000;
    ov_nxt  = 1'b0;
    un_nxt  = 1'b0;
    if (mant_q == 25'd0) begin
      res_nxt = 32'h0000_0000;
    end else if (mant_q[24]) begin
      if (exp_inc >= 9'd255) begin
        res_nxt = {sign_q, 8'hFF, 23'd0};
        ov_nxt  = 1'b1;
      end else begin
        res_nxt = {sign_q, exp_inc[7:0], mant_q[23:1]};
      end
    end else if (mant_q[23] && exp_q != 8'h00 && exp_q != 8'hFF) begin
      res_nxt = {sign_q, exp_q, mant_q[22:0]};
    end else if (exp_q == 8'hFF) begin
      res_nxt = {sign_q, 8'hFF, 23'd0};
      ov_nxt  = 1'b1;
    end else if (exp_q <= 8'd1) begin
      res_nxt = 32'h0000_0000;
      un_nxt  = 1'b1;
    end else begin
      fin = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      result    <= 32'h0000_0000;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= 8'h00;
      mant_q    <= 25'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_sign;
            exp_q    <= in_exp;
            mant_q   <= in_mant;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (fin) begin
            result    <= res_nxt;
            overflow  <= ov_nxt;
            underflow <= un_nxt;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            // exp_q >= 2 here, so the decrement never drops below 1.
            mant_q <= {mant_q[23:0], 1'b0};
            exp_q  <= exp_q - 8'd1;
          end
        end
        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
